scan_controller: RTL and testbench

- Parametrised successor of the fixed 8-digit anode scanner: drives N active-low digit enables for a multiplexed 7-segment display, one digit per slot.
- Adds a per-digit enable mask (disabled digits skipped), an exported digit index for segment-data muxing, a frame-start strobe, and optional per-slot PWM dimming.
- Sits between the tick divider and the segment decoder/mux in the display path.

---
 rtl/scan_controller.sv | 142 ++++++++++++++
 tb/tb_scan_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_controller.sv
// rtl/scan_controller.sv - multiplexed 7-segment digit scanner with enable mask, frame strobe and optional PWM dimming
// Optional dimming is built when SCAN_CONTROLLER_DIMMING_EN is defined.
module scan_controller #(
    parameter int NUM_DIGITS = 8,
    parameter int IDX_W      = 3,
    parameter int PWM_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic [NUM_DIGITS-1:0] enable_mask,
    input  logic [PWM_W-1:0]      brightness,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [IDX_W-1:0]      digit_sel,
    output logic                  frame_start
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [IDX_W-1:0]        sel_nx;
    logic [IDX_W-1:0]        lowest_idx;
    logic [IDX_W-1:0]        above_idx;
    logic [IDX_W-1:0]        next_idx;
    logic                    found_above;
    logic                    mask_any;
    logic                    fs_nx;
    logic                    slot_end;
    logic                    pwm_on;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [NUM_DIGITS-1:0]   anode_nx;

`ifdef SCAN_CONTROLLER_DIMMING_EN
    logic [PWM_W-1:0]        sub_cnt;
    logic [PWM_W-1:0]        sub_nx;

    assign slot_end = &sub_cnt;
    assign pwm_on   = (sub_nx <= brightness);
`else
    logic                    unused_brightness;

    assign slot_end          = 1'b1;
    assign pwm_on            = 1'b1;
    assign unused_brightness = ^brightness;
`endif

    assign mask_any = |enable_mask;

    // Lowest enabled digit, and lowest enabled digit strictly above the current one.
    always_comb begin
        lowest_idx  = '0;
        above_idx   = '0;
        found_above = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (enable_mask[i]) begin
                lowest_idx = IDX_W'(i);
                if (IDX_W'(i) > digit_sel) begin
                    above_idx   = IDX_W'(i);
                    found_above = 1'b1;
                end
            end
        end
    end

    // Nothing enabled above: wrap to the lowest enabled digit (may be digit_sel itself).
    assign next_idx = found_above ? above_idx : lowest_idx;

    always_comb begin
        state_nx = state;
        sel_nx   = digit_sel;
        fs_nx    = 1'b0;
`ifdef SCAN_CONTROLLER_DIMMING_EN
        sub_nx   = sub_cnt;
`endif
        case (state)
            IDLE: begin
                if (tick && mask_any) begin
                    state_nx = SCAN;
                    sel_nx   = lowest_idx;
                    fs_nx    = 1'b1;
`ifdef SCAN_CONTROLLER_DIMMING_EN
                    sub_nx   = '0;
`endif
                end
            end
            SCAN: begin
                if (!mask_any) begin
                    state_nx = IDLE;
                end else if (tick) begin
                    if (slot_end) begin
                        sel_nx = next_idx;
                        fs_nx  = (next_idx <= digit_sel);
`ifdef SCAN_CONTROLLER_DIMMING_EN
                        sub_nx = '0;
`endif
                    end
`ifdef SCAN_CONTROLLER_DIMMING_EN
                    else begin
                        sub_nx = sub_cnt + 1'b1;
                    end
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Anode is computed from next-state index so it moves on the same edge as digit_sel.
    assign sel_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << sel_nx;

    always_comb begin
        anode_nx = '1;
        if (state_nx == SCAN && pwm_on) begin
            anode_nx = ~(enable_mask & sel_onehot);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            digit_sel   <= '0;
            anode       <= '1;
            frame_start <= 1'b0;
`ifdef SCAN_CONTROLLER_DIMMING_EN
            sub_cnt     <= '0;
`endif
        end else begin
            state       <= state_nx;
            digit_sel   <= sel_nx;
            anode       <= anode_nx;
            frame_start <= fs_nx && !frame_start;
`ifdef SCAN_CONTROLLER_DIMMING_EN
            sub_cnt     <= sub_nx;
`endif
        end
    end

endmodule

// File: tb/tb_scan_controller.sv
// tb/tb_scan_controller.sv - vector table, corner sequences and randomized model check for scan_controller
module tb_scan_controller;

    localparam int N = 8;
`ifdef SCAN_CONTROLLER_DIMMING_EN
    localparam int SLOT = 16;
`else
    localparam int SLOT = 1;
`endif

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic [7:0] enable_mask;
    logic [3:0] brightness;
    logic [7:0] anode;
    logic [2:0] digit_sel;
    logic       frame_start;

    int vectors;
    int miscompares;

    scan_controller #(.NUM_DIGITS(8), .IDX_W(3), .PWM_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .enable_mask (enable_mask),
        .brightness  (brightness),
        .anode       (anode),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       t;
        logic [7:0] m;
        logic [7:0] exp_anode;
        logic [2:0] exp_sel;
        logic       exp_fs;
    } vec_t;

    vec_t vecs[$];

    // Reference model: scan position as plain integers.
    bit   m_scan;
    int   m_idx;
    int   m_sub;
    logic m_fs;

    function automatic int next_enabled(int from, logic [7:0] mask);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (from + k) % N;
            if (((mask >> j) & 8'h01) != 8'h00) return j;
        end
        return from;
    endfunction

    function automatic logic [7:0] model_anode(logic [7:0] mask, logic [3:0] b);
        bit lit;
        lit = m_scan && (((mask >> m_idx) & 8'h01) != 8'h00);
        if (SLOT > 1) lit = lit && (m_sub <= int'(b));
        return lit ? ~(8'h01 << m_idx) : 8'hFF;
    endfunction

    task automatic model_reset();
        m_scan = 1'b0;
        m_idx  = 0;
        m_sub  = 0;
        m_fs   = 1'b0;
    endtask

    task automatic model_step(logic t, logic [7:0] mask);
        bit fs;
        int old;
        fs = 1'b0;
        if (!m_scan) begin
            if (t && mask != 8'h00) begin
                m_scan = 1'b1;
                m_idx  = next_enabled(N - 1, mask);
                m_sub  = 0;
                fs     = 1'b1;
            end
        end else if (mask == 8'h00) begin
            m_scan = 1'b0;
        end else if (t) begin
            if (m_sub < SLOT - 1) begin
                m_sub++;
            end else begin
                old   = m_idx;
                m_sub = 0;
                m_idx = next_enabled(old, mask);
                fs    = (m_idx <= old);
            end
        end
        m_fs = fs && !m_fs;
    endtask

    task automatic check(string name, logic [7:0] ea, logic [2:0] es, logic ef);
        vectors++;
        if (anode !== ea || digit_sel !== es || frame_start !== ef) begin
            miscompares++;
            $display("FAIL %s: got anode=%h sel=%0d fs=%b, expected anode=%h sel=%0d fs=%b",
                     name, anode, digit_sel, frame_start, ea, es, ef);
        end
    endtask

    // One clock: inputs set at negedge, model advanced at posedge, outputs ready #1 later.
    task automatic drive(logic t, logic [7:0] m, logic [3:0] b);
        @(negedge clk);
        tick        = t;
        enable_mask = m;
        brightness  = b;
        @(posedge clk);
        model_step(t, m);
        #1;
    endtask

    task automatic add(logic t, logic [7:0] m, logic [7:0] a, logic [2:0] s, logic f);
        vecs.push_back('{t: t, m: m, exp_anode: a, exp_sel: s, exp_fs: f});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        tick        = 1'b0;
        enable_mask = 8'h00;
        brightness  = 4'd0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset", 8'hFF, 3'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 8'hFF, 4'd0);
        check("idle_no_tick", 8'hFF, 3'd0, 1'b0);

`ifndef SCAN_CONTROLLER_DIMMING_EN
        // Full mask walk and wrap.
        add(1, 8'hFF, 8'hFE, 0, 1);
        add(1, 8'hFF, 8'hFD, 1, 0);
        add(1, 8'hFF, 8'hFB, 2, 0);
        add(1, 8'hFF, 8'hF7, 3, 0);
        add(1, 8'hFF, 8'hEF, 4, 0);
        add(1, 8'hFF, 8'hDF, 5, 0);
        add(1, 8'hFF, 8'hBF, 6, 0);
        add(1, 8'hFF, 8'h7F, 7, 0);
        add(1, 8'hFF, 8'hFE, 0, 1);
        add(0, 8'hFF, 8'hFE, 0, 0);
        // Sparse mask 1010_0100.
        add(1, 8'hA4, 8'hFB, 2, 0);
        add(1, 8'hA4, 8'hDF, 5, 0);
        add(1, 8'hA4, 8'h7F, 7, 0);
        add(1, 8'hA4, 8'hFB, 2, 1);
        add(1, 8'hA4, 8'hDF, 5, 0);
        // Single enabled digit.
        add(1, 8'h08, 8'hF7, 3, 1);
        add(0, 8'h08, 8'hF7, 3, 0);
        add(1, 8'h08, 8'hF7, 3, 1);
        add(0, 8'h08, 8'hF7, 3, 0);
        add(1, 8'h08, 8'hF7, 3, 1);
        // Empty mask drops to idle without tick, then restart.
        add(0, 8'h00, 8'hFF, 3, 0);
        add(0, 8'h00, 8'hFF, 3, 0);
        add(1, 8'h24, 8'hFB, 2, 1);
        // Current digit disabled mid-slot, then advance.
        add(0, 8'h20, 8'hFF, 2, 0);
        add(1, 8'h20, 8'hDF, 5, 0);
        add(0, 8'hFF, 8'hDF, 5, 0);
        // Mask change coincident with tick.
        add(1, 8'h81, 8'h7F, 7, 0);
        add(1, 8'h81, 8'hFE, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].t, vecs[i].m, 4'd0);
            check($sformatf("vec%0d", i), vecs[i].exp_anode, vecs[i].exp_sel, vecs[i].exp_fs);
        end
`else
        // Dimming: brightness 3 gives 4 lit ticks out of 16 per digit.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) begin
                logic [7:0] ea;
                logic [7:0] on_pat;
                on_pat = ~(8'h01 << d);
                ea     = (k <= 3) ? on_pat : 8'hFF;
                drive(1'b1, 8'hFF, 4'd3);
                check($sformatf("dim_d%0d_k%0d", d, k), ea, 3'(d), (d == 0 && k == 0));
                drive(1'b0, 8'hFF, 4'd3);
            end
        end
`endif

        // Asynchronous reset mid-slot, asserted between clock edges.
        drive(1'b0, 8'hFF, 4'd15);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 8'hFF, 3'd0, 1'b0);
        model_reset();
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'hFF, 4'd15);
            check("post_reset_idle", 8'hFF, 3'd0, 1'b0);
        end

        // Randomized stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            logic       t;
            logic [7:0] m;
            logic [3:0] b;
            t = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0)      m = 8'h00;
            else if ($urandom_range(0, 3) == 0)  m = 8'h01 << $urandom_range(0, 7);
            else                                 m = 8'($urandom);
            if (i % 40 >= 5 && m == 8'h00) m = enable_mask;
            if ($urandom_range(0, 3) != 0 && enable_mask != 8'h00) m = enable_mask;
            b = 4'($urandom);
            drive(t, m, b);
            check($sformatf("rand%0d", i), model_anode(m, b), 3'(m_idx), m_fs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
